// File: rtl/customnios_cpu_debug_pkg.sv
// Shared types and jdo field positions for the OCI memory-access sequencer.
package customnios_cpu_debug_pkg;

    // Sequencer states: idle, Avalon read in flight, Avalon write in flight.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2
    } ocimem_state_e;

    // Bit positions inside the 38-bit jdo word.
    localparam int ADDR_LSB  = 17;
    localparam int RD_GO_BIT = 34;
    localparam int CLR_BIT   = 35;
    localparam int WDATA_LSB = 3;
    localparam int WDATA_MSB = 34;

    // Number of command strobes raised in one cycle (0..3).
    function automatic logic [1:0] strobe_count(input logic a, input logic b, input logic c);
        return {1'b0, a} + {1'b0, b} + {1'b0, c};
    endfunction

endpackage

// File: rtl/customnios_cpu_debug_wait_timer.sv
// Loadable up-counter of waitrequest stall cycles; flags the last allowed stall.
module customnios_cpu_debug_wait_timer #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr,
    input  logic inc,
    output logic expired
);

    localparam int              CW   = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]   LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt_d;
    logic [CW-1:0] cnt_q;

    // Next count: clear on access entry, otherwise count stall cycles.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // A stall seen while the count sits at TIMEOUT-1 is the TIMEOUT-th one.
    assign expired = (cnt_q == LAST);

endmodule

// File: rtl/customnios_cpu_debug_ocimem_seq.sv
// Debug-side single-word Avalon-MM access sequencer with address auto-increment.
//
// Handshake: the Avalon master holds avm_read/avm_write, avm_address and
// avm_writedata stable while avm_waitrequest=1; a transfer completes on the
// rising edge where the request is high and avm_waitrequest=0 (read data is
// taken at that same edge). Command strobes are one-cycle pulses with no
// back-pressure: a strobe that cannot be taken is dropped and flagged.
module customnios_cpu_debug_ocimem_seq
    import customnios_cpu_debug_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [37:0]       jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic              take_no_action_ocimem_a,
    output logic [ADDR_W+1:0] avm_address,
    output logic              avm_read,
    output logic              avm_write,
    output logic [31:0]       avm_writedata,
    input  logic [31:0]       avm_readdata,
    input  logic              avm_waitrequest,
    output logic [31:0]       MonDReg,
    output logic              ocimem_busy,
    output logic              ocimem_overrun,
    output logic              ocimem_timeout,
    output logic [1:0]        dbg_state
);

    ocimem_state_e     state_d, state_q;
    logic [ADDR_W-1:0] mona_d, mona_q;
    logic [31:0]       wdata_d, wdata_q;
    logic [31:0]       mondreg_d, mondreg_q;
    logic              overrun_d, overrun_q;
    logic              timeout_d, timeout_q;
    logic              busy_d, busy_q;
    logic              read_d, read_q;
    logic              write_d, write_q;

    logic              tmr_clr;
    logic              tmr_inc;
    logic              tmr_expired;
    logic              set_overrun;
    logic              set_timeout;
    logic              clr_flags;
    logic [1:0]        n_strobes;

    customnios_cpu_debug_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (tmr_clr),
        .inc     (tmr_inc),
        .expired (tmr_expired)
    );

    // Command decode, access progress, timeout abort and sticky status.
    always_comb begin
        state_d     = state_q;
        mona_d      = mona_q;
        wdata_d     = wdata_q;
        mondreg_d   = mondreg_q;
        tmr_clr     = 1'b0;
        tmr_inc     = 1'b0;
        set_overrun = 1'b0;
        set_timeout = 1'b0;
        clr_flags   = 1'b0;
        n_strobes   = strobe_count(take_action_ocimem_a, take_action_ocimem_b,
                                   take_no_action_ocimem_a);

        case (state_q)
            ST_IDLE: begin
                if (busy_q) begin
                    // Completion tail cycle: still busy, so any command is lost.
                    if (n_strobes != 2'd0) set_overrun = 1'b1;
                end else begin
                    if (take_action_ocimem_a) begin
                        mona_d = jdo[ADDR_LSB +: ADDR_W];
                        if (jdo[RD_GO_BIT]) begin
                            state_d = ST_RD;
                            tmr_clr = 1'b1;
                        end
                        if (jdo[CLR_BIT]) clr_flags = 1'b1;
                    end else if (take_action_ocimem_b) begin
                        wdata_d = jdo[WDATA_MSB:WDATA_LSB];
                        state_d = ST_WR;
                        tmr_clr = 1'b1;
                    end else if (take_no_action_ocimem_a) begin
                        mona_d  = mona_q + ADDR_W'(1);
                        state_d = ST_RD;
                        tmr_clr = 1'b1;
                    end
                    // Lower-priority strobes in the same cycle are discarded.
                    if (n_strobes > 2'd1) set_overrun = 1'b1;
                end
            end
            ST_RD, ST_WR: begin
                if (n_strobes != 2'd0) set_overrun = 1'b1;
                if (!avm_waitrequest) begin
                    if (state_q == ST_RD) begin
                        mondreg_d = avm_readdata;
                    end else begin
                        mona_d = mona_q + ADDR_W'(1);
                    end
                    state_d = ST_IDLE;
                end else if (tmr_expired) begin
                    // Abort: address and read data are left untouched.
                    state_d     = ST_IDLE;
                    set_timeout = 1'b1;
                end else begin
                    tmr_inc = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A clear from the command word wins over a same-cycle set.
        overrun_d = clr_flags ? 1'b0 : (overrun_q | set_overrun);
        timeout_d = clr_flags ? 1'b0 : (timeout_q | set_timeout);

        // Busy covers the access itself plus one completion cycle.
        busy_d  = (state_d != ST_IDLE) || (state_q != ST_IDLE);
        read_d  = (state_d == ST_RD);
        write_d = (state_d == ST_WR);
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            mona_q    <= '0;
            wdata_q   <= '0;
            mondreg_q <= '0;
            overrun_q <= 1'b0;
            timeout_q <= 1'b0;
            busy_q    <= 1'b0;
            read_q    <= 1'b0;
            write_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            mona_q    <= mona_d;
            wdata_q   <= wdata_d;
            mondreg_q <= mondreg_d;
            overrun_q <= overrun_d;
            timeout_q <= timeout_d;
            busy_q    <= busy_d;
            read_q    <= read_d;
            write_q   <= write_d;
        end
    end

    assign avm_address    = {mona_q, 2'b00};
    assign avm_read       = read_q;
    assign avm_write      = write_q;
    assign avm_writedata  = wdata_q;
    assign MonDReg        = mondreg_q;
    assign ocimem_busy    = busy_q;
    assign ocimem_overrun = overrun_q;
    assign ocimem_timeout = timeout_q;
    assign dbg_state      = state_q;

endmodule

// File: tb/tb_customnios_cpu_debug_ocimem_seq.sv
// Directed bench: dut_a uses the default TIMEOUT, dut_b uses TIMEOUT=4.
// Both share the same stimulus.
module tb_customnios_cpu_debug_ocimem_seq;

  logic        clk;
  logic        reset_n;
  logic [37:0] jdo;
  logic        take_action_ocimem_a;
  logic        take_action_ocimem_b;
  logic        take_no_action_ocimem_a;
  logic [31:0] avm_readdata;
  logic        avm_waitrequest;

  logic [9:0]  a_address, b_address;
  logic        a_read, b_read, a_write, b_write;
  logic [31:0] a_wdata, b_wdata, a_mond, b_mond;
  logic        a_busy, b_busy, a_ovr, b_ovr, a_to, b_to;
  logic [1:0]  a_dbg, b_dbg;

  int n_cmp;
  int n_bad;

  customnios_cpu_debug_ocimem_seq #(.ADDR_W(8), .TIMEOUT(255)) dut_a (
    .clk(clk), .reset_n(reset_n), .jdo(jdo),
    .take_action_ocimem_a(take_action_ocimem_a),
    .take_action_ocimem_b(take_action_ocimem_b),
    .take_no_action_ocimem_a(take_no_action_ocimem_a),
    .avm_address(a_address), .avm_read(a_read), .avm_write(a_write),
    .avm_writedata(a_wdata), .avm_readdata(avm_readdata),
    .avm_waitrequest(avm_waitrequest), .MonDReg(a_mond),
    .ocimem_busy(a_busy), .ocimem_overrun(a_ovr), .ocimem_timeout(a_to),
    .dbg_state(a_dbg)
  );

  customnios_cpu_debug_ocimem_seq #(.ADDR_W(8), .TIMEOUT(4)) dut_b (
    .clk(clk), .reset_n(reset_n), .jdo(jdo),
    .take_action_ocimem_a(take_action_ocimem_a),
    .take_action_ocimem_b(take_action_ocimem_b),
    .take_no_action_ocimem_a(take_no_action_ocimem_a),
    .avm_address(b_address), .avm_read(b_read), .avm_write(b_write),
    .avm_writedata(b_wdata), .avm_readdata(avm_readdata),
    .avm_waitrequest(avm_waitrequest), .MonDReg(b_mond),
    .ocimem_busy(b_busy), .ocimem_overrun(b_ovr), .ocimem_timeout(b_to),
    .dbg_state(b_dbg)
  );

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to 1 time unit past the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [37:0] mk_a(input logic [7:0] addr, input logic rd, input logic clr);
    logic [37:0] j;
    j = '0;
    j[24:17] = addr;
    j[34] = rd;
    j[35] = clr;
    return j;
  endfunction

  function automatic logic [37:0] mk_b(input logic [31:0] d);
    logic [37:0] j;
    j = '0;
    j[34:3] = d;
    return j;
  endfunction

  task automatic no_strobe();
    take_action_ocimem_a    = 1'b0;
    take_action_ocimem_b    = 1'b0;
    take_no_action_ocimem_a = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset_n = 1'b0;
    jdo = '0;
    no_strobe();
    avm_readdata = '0;
    avm_waitrequest = 1'b0;

    // Reset state
    #12;
    check_val("rst_addr", a_address, 10'h000);
    check_val("rst_read", a_read, 1'b0);
    check_val("rst_busy", a_busy, 1'b0);
    check_val("rst_mond", a_mond, 32'h0);
    reset_n = 1'b1;
    tick();

    // Load/read: addr 0x10, immediate ack
    jdo = mk_a(8'h10, 1'b1, 1'b0);
    take_action_ocimem_a = 1'b1;
    avm_readdata = 32'hCAFEF00D;
    tick();
    no_strobe();
    check_val("ld_read_e", a_read, 1'b1);
    check_val("ld_addr", a_address, 10'h040);
    check_val("ld_busy_e", a_busy, 1'b1);
    check_val("ld_dbg", a_dbg, 2'd1);
    tick();
    check_val("ld_read_e1", a_read, 1'b0);
    check_val("ld_busy_e1", a_busy, 1'b1);
    tick();
    check_val("ld_busy_e2", a_busy, 1'b0);
    check_val("ld_mond", a_mond, 32'hCAFEF00D);

    // Auto-increment write at 0xFF wraps to 0x00, then next read at 0x01
    jdo = mk_a(8'hFF, 1'b0, 1'b0);
    take_action_ocimem_a = 1'b1;
    tick();
    no_strobe();
    check_val("wr_preaddr", a_address, 10'h3FC);
    check_val("wr_prebusy", a_busy, 1'b0);
    jdo = mk_b(32'h12345678);
    take_action_ocimem_b = 1'b1;
    tick();
    no_strobe();
    check_val("wr_write", a_write, 1'b1);
    check_val("wr_addr", a_address, 10'h3FC);
    check_val("wr_data", a_wdata, 32'h12345678);
    tick();
    check_val("wr_write_off", a_write, 1'b0);
    check_val("wr_wrap", a_address, 10'h000);
    tick();
    take_no_action_ocimem_a = 1'b1;
    avm_readdata = 32'hA5A50001;
    tick();
    no_strobe();
    check_val("inc_read", a_read, 1'b1);
    check_val("inc_addr", a_address, 10'h004);
    tick();
    check_val("inc_mond", a_mond, 32'hA5A50001);
    tick();

    // Timeout on dut_b (TIMEOUT=4); dut_a keeps waiting
    jdo = mk_a(8'h30, 1'b1, 1'b0);
    take_action_ocimem_a = 1'b1;
    avm_waitrequest = 1'b1;
    avm_readdata = 32'hDEADDEAD;
    tick();
    no_strobe();
    for (int i = 0; i < 3; i++) begin
      check_val("to_read_held", b_read, 1'b1);
      tick();
    end
    check_val("to_read_held4", b_read, 1'b1);
    tick();
    check_val("to_dropped", b_read, 1'b0);
    check_val("to_flag", b_to, 1'b1);
    check_val("to_mond", b_mond, 32'hA5A50001);
    check_val("to_addr", b_address, 10'h0C0);
    check_val("to_a_still", a_read, 1'b1);
    avm_waitrequest = 1'b0;
    tick();
    check_val("to_a_mond", a_mond, 32'hDEADDEAD);
    check_val("to_a_noflag", a_to, 1'b0);
    tick();
    tick();
    jdo = mk_a(8'h30, 1'b0, 1'b1);
    take_action_ocimem_a = 1'b1;
    tick();
    no_strobe();
    check_val("to_clear", b_to, 1'b0);

    // Five-cycle stall on dut_a
    jdo = mk_a(8'h20, 1'b1, 1'b0);
    take_action_ocimem_a = 1'b1;
    avm_waitrequest = 1'b1;
    tick();
    no_strobe();
    for (int i = 0; i < 5; i++) begin
      avm_readdata = 32'h1000 + i;
      check_val("st_read", a_read, 1'b1);
      check_val("st_addr", a_address, 10'h080);
      check_val("st_mond", a_mond, 32'hDEADDEAD);
      tick();
    end
    avm_waitrequest = 1'b0;
    avm_readdata = 32'hFEEDBEEF;
    check_val("st_read6", a_read, 1'b1);
    tick();
    check_val("st_done", a_read, 1'b0);
    check_val("st_mond_final", a_mond, 32'hFEEDBEEF);
    tick();
    check_val("st_idle", a_busy, 1'b0);
    // Clear the timeout dut_b raised during this stall
    jdo = mk_a(8'h20, 1'b0, 1'b1);
    take_action_ocimem_a = 1'b1;
    tick();
    no_strobe();

    // Overrun: strobe during busy is ignored
    jdo = mk_a(8'h40, 1'b1, 1'b0);
    take_action_ocimem_a = 1'b1;
    avm_waitrequest = 1'b1;
    tick();
    jdo = mk_a(8'h55, 1'b1, 1'b0);
    tick();
    no_strobe();
    check_val("ov_flag", a_ovr, 1'b1);
    check_val("ov_addr", a_address, 10'h100);
    avm_waitrequest = 1'b0;
    tick();
    tick();
    check_val("ov_addr_kept", a_address, 10'h100);
    check_val("ov_idle", a_busy, 1'b0);
    jdo = mk_a(8'h40, 1'b0, 1'b1);
    take_action_ocimem_a = 1'b1;
    tick();
    no_strobe();
    check_val("ov_clear", a_ovr, 1'b0);

    // Simultaneous a and b: only a executes
    jdo = mk_a(8'h07, 1'b0, 1'b0);
    take_action_ocimem_a = 1'b1;
    take_action_ocimem_b = 1'b1;
    tick();
    no_strobe();
    check_val("sim_write", a_write, 1'b0);
    check_val("sim_addr", a_address, 10'h01C);
    check_val("sim_ovr", a_ovr, 1'b1);
    check_val("sim_busy", a_busy, 1'b0);

    // Reset during a stalled write
    jdo = mk_b(32'h0000ABCD);
    take_action_ocimem_b = 1'b1;
    avm_waitrequest = 1'b1;
    tick();
    no_strobe();
    check_val("rw_write", a_write, 1'b1);
    tick();
    reset_n = 1'b0;
    #1;
    check_val("rw_write_off", a_write, 1'b0);
    check_val("rw_busy", a_busy, 1'b0);
    check_val("rw_addr", a_address, 10'h000);
    check_val("rw_ovr", a_ovr, 1'b0);
    check_val("rw_mond", a_mond, 32'h0);
    check_val("rw_wdata", a_wdata, 32'h0);
    #2;
    reset_n = 1'b1;
    avm_waitrequest = 1'b0;
    tick();
    check_val("rw_post_addr", a_address, 10'h000);
    check_val("rw_post_write", a_write, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
